lot_occupancy: RTL and testbench

- Sequential front end for the parking-lot meter.
- Watches two beam-break sensors at a single-lane gate, decodes the ordered break/clear sequence into car-entered and car-exited events, and keeps the occupancy count.
- Its `cars` output is the occupancy bus that the hex-display decoder consumes.
- Sits between the gate GPIO pins and the display decoder.

---
 rtl/lot_pkg.sv | 27 ++
 rtl/sync_bit.sv | 29 ++
 rtl/lot_occupancy.sv | 162 ++++++++++++++++
 tb/tb_lot_occupancy.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lot_pkg
// Description : Shared gate-FSM state type and beam-pair encodings
// Revision    : 1.0 - initial release
// ============================================================================
package lot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IN1  = 3'd1,
        IN2  = 3'd2,
        IN3  = 3'd3,
        OUT1 = 3'd4,
        OUT2 = 3'd5,
        OUT3 = 3'd6,
        WAIT = 3'd7
    } gate_state_t;

    // Pair is {a, b}; a is the outer beam
    localparam logic [1:0] S_CLR = 2'b00;
    localparam logic [1:0] S_A   = 2'b10;
    localparam logic [1:0] S_AB  = 2'b11;
    localparam logic [1:0] S_B   = 2'b01;

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Multi-flop synchronizer for one asynchronous level input
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/lot_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : lot_occupancy
// Description : Two-beam gate decoder with saturating parking occupancy count
// Revision    : 1.0 - initial release
// ============================================================================
module lot_occupancy
    import lot_pkg::*;
#(
    parameter int CAPACITY    = 3,
    parameter int SYNC_STAGES = 2,
    localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic [CNT_W-1:0] cars,
    output logic             full,
    output logic             empty,
    output logic             car_enter,
    output logic             car_exit,
    output logic             err
);

    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    logic        a_sync;
    logic        b_sync;
    logic [1:0]  ab;

    gate_state_t state_q, state_d;
    logic        enter_req, exit_req, jump_err;

    logic [CNT_W-1:0] cars_q, cars_d;
    logic             full_q, empty_q;
    logic             enter_q, enter_d;
    logic             exit_q, exit_d;
    logic             err_q, err_d;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (sensor_a),
        .q_o     (a_sync)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (sensor_b),
        .q_o     (b_sync)
    );

    assign ab = {a_sync, b_sync};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any two-bit change of the pair is a jump: flag it and park in WAIT until clear
    always_comb begin
        state_d   = state_q;
        enter_req = 1'b0;
        exit_req  = 1'b0;
        jump_err  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ab == S_A)       state_d = IN1;
                else if (ab == S_B)  state_d = OUT1;
                else if (ab == S_AB) begin state_d = WAIT; jump_err = 1'b1; end
            end
            IN1: begin
                if (ab == S_AB)       state_d = IN2;
                else if (ab == S_CLR) state_d = IDLE;
                else if (ab == S_B)   begin state_d = WAIT; jump_err = 1'b1; end
            end
            IN2: begin
                if (ab == S_B)        state_d = IN3;
                else if (ab == S_A)   state_d = IN1;
                else if (ab == S_CLR) begin state_d = WAIT; jump_err = 1'b1; end
            end
            IN3: begin
                if (ab == S_CLR)      begin state_d = IDLE; enter_req = 1'b1; end
                else if (ab == S_AB)  state_d = IN2;
                else if (ab == S_A)   begin state_d = WAIT; jump_err = 1'b1; end
            end
            OUT1: begin
                if (ab == S_AB)       state_d = OUT2;
                else if (ab == S_CLR) state_d = IDLE;
                else if (ab == S_A)   begin state_d = WAIT; jump_err = 1'b1; end
            end
            OUT2: begin
                if (ab == S_A)        state_d = OUT3;
                else if (ab == S_B)   state_d = OUT1;
                else if (ab == S_CLR) begin state_d = WAIT; jump_err = 1'b1; end
            end
            OUT3: begin
                if (ab == S_CLR)      begin state_d = IDLE; exit_req = 1'b1; end
                else if (ab == S_AB)  state_d = OUT2;
                else if (ab == S_B)   begin state_d = WAIT; jump_err = 1'b1; end
            end
            WAIT: begin
                if (ab == S_CLR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cars_d  = cars_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = jump_err;
        if (enter_req) begin
            if (cars_q == CAP_C) begin
                err_d = 1'b1;
            end else begin
                cars_d  = cars_q + CNT_W'(1);
                enter_d = 1'b1;
            end
        end else if (exit_req) begin
            if (cars_q == '0) begin
                err_d = 1'b1;
            end else begin
                cars_d = cars_q - CNT_W'(1);
                exit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cars_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cars_q  <= cars_d;
            full_q  <= (cars_d == CAP_C);
            empty_q <= (cars_d == '0);
            enter_q <= enter_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    assign cars      = cars_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign car_enter = enter_q;
    assign car_exit  = exit_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lot_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : tb_lot_occupancy
// Description : Directed and random-walk bench for lot_occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lot_occupancy;
    import lot_pkg::*;

    localparam int CAP = 3;
    localparam int SS  = 2;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sensor_a = 1'b0;
    logic          sensor_b = 1'b0;
    logic [CW-1:0] cars;
    logic          full, empty, car_enter, car_exit, err;

    int checks = 0;
    int errors = 0;

    // Reference: the pair walks a ring 00->10->11->01->00; a full lap forward is
    // an entry, a full lap backward an exit, a two-step jump is illegal.
    logic [1:0] hist [SS];
    logic [1:0] m_prev;
    int         m_disp, m_cars;
    bit         m_wait, e_en, e_ex, e_err;
    int         n_enter;
    logic [1:0] pat [$];

    lot_occupancy #(.CAPACITY(CAP), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .cars      (cars),
        .full      (full),
        .empty     (empty),
        .car_enter (car_enter),
        .car_exit  (car_exit),
        .err       (err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ring(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SS; i++) hist[i] = 2'b00;
        m_prev = 2'b00; m_disp = 0; m_cars = 0; m_wait = 0;
        e_en = 0; e_ex = 0; e_err = 0;
    endtask

    task automatic model_proc(input logic [1:0] v);
        int d;
        e_en = 0; e_ex = 0; e_err = 0;
        if (m_wait) begin
            if (v == 2'b00) m_wait = 0;
        end else begin
            d = (pos(v) - pos(m_prev) + 4) % 4;
            if (d == 2) begin
                m_wait = 1; m_disp = 0; e_err = 1;
            end else begin
                if (d == 1) m_disp++;
                else if (d == 3) m_disp--;
                if (v == 2'b00) begin
                    if (m_disp == 4) begin
                        if (m_cars < CAP) begin m_cars++; e_en = 1; end
                        else e_err = 1;
                    end else if (m_disp == -4) begin
                        if (m_cars > 0) begin m_cars--; e_ex = 1; end
                        else e_err = 1;
                    end
                    m_disp = 0;
                end
            end
        end
        m_prev = v;
    endtask

    task automatic check_all();
        check("cars",      32'(cars),      32'(m_cars));
        check("full",      32'(full),      32'(m_cars == CAP));
        check("empty",     32'(empty),     32'(m_cars == 0));
        check("car_enter", 32'(car_enter), 32'(e_en));
        check("car_exit",  32'(car_exit),  32'(e_ex));
        check("err",       32'(err),       32'(e_err));
    endtask

    // Drive v for n cycles; inputs change on the falling edge, outputs checked there too
    task automatic cyc(input logic [1:0] v, input int n);
        logic [1:0] oldest;
        for (int k = 0; k < n; k++) begin
            {sensor_a, sensor_b} = v;
            @(posedge clk);
            oldest = hist[SS-1];
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {sensor_a, sensor_b};
            model_proc(oldest);
            @(negedge clk);
            check_all();
            if (car_enter === 1'b1) n_enter++;
        end
    endtask

    task automatic walk(input int hold);
        foreach (pat[i]) cyc(pat[i], hold);
    endtask

    initial begin
        logic [1:0] v;
        int         p, r;
        model_reset();
        n_enter = 0;

        // Reset then idle
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cars",  32'(cars),  32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_pulse", 32'({car_enter, car_exit, err}), 32'd0);
        reset_n = 1'b1;
        cyc(2'b00, 10);

        // Three entries then one while full
        pat = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        repeat (3) walk(4);
        check("enter_count3", 32'(n_enter), 32'd3);
        walk(4);
        check("enter_when_full", 32'(n_enter), 32'd3);

        // Exits down to empty, then underflow
        pat = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        repeat (4) walk(4);

        // Abort, then back-up entry
        pat = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b00};
        walk(4);
        n_enter = 0;
        pat = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00};
        walk(4);
        check("backup_enter", 32'(n_enter), 32'd1);

        // Illegal jump, wander while waiting, then resume
        pat = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        walk(4);
        pat = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        walk(4);

        // Async reset while in IN2 with two cars
        pat = '{2'b00, 2'b10, 2'b11};
        walk(4);
        check("pre_rst_cars", 32'(cars), 32'd2);
        #5;
        reset_n = 1'b0;
        #1;
        check("arst_cars",  32'(cars),       32'd0);
        check("arst_empty", 32'(empty),      32'd1);
        check("arst_state", 32'(dut.state_q), 32'(IDLE));
        {sensor_a, sensor_b} = 2'b00;
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        cyc(2'b00, 4);

        // Random walk: forward-biased half, then backward-biased half
        p = 0;
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 15);
            if (r == 0)                        p = p + 2;
            else if ((r < 11) == (s < 200))    p = p + 1;
            else                               p = p + 3;
            v = ring(p);
            cyc(v, $urandom_range(1, 4));
        end
        cyc(2'b00, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
